// File: rtl/cpu_ctrl_if.sv
// Handshake bundle between the CPU microsequencer and its surroundings.
// The sequencer drives the control word and status through the slave modport.
interface cpu_ctrl_if;
  logic        start;
  logic [7:0]  ir_opcode;
  logic        acc_sign;
  logic [15:0] control_signals;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;

  modport master (
    output start, ir_opcode, acc_sign,
    input  control_signals, halted, illegal_op, instr_count
  );

  modport slave (
    input  start, ir_opcode, acc_sign,
    output control_signals, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute microsequencer for the single-accumulator CPU.
// It emits the 16-bit datapath control word, stretches RAM reads and stops on HALT.
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic       clk,
  input logic       rst_n,
  cpu_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_JU, S_E0,
    S_ST1, S_ST2, S_RD, S_BR, S_EA, S_HLT
  } state_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h08;
  localparam logic [7:0] OP_OR     = 8'h09;
  localparam logic [7:0] OP_NOT    = 8'h0A;
  localparam logic [7:0] OP_SHR    = 8'h0B;

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic        wait_done;
  logic        retire;
  logic [15:0] instr_count_q;
  logic [15:0] cw_q;
  logic        halted_q;

  function automatic logic [2:0] alu_of(input logic [7:0] op);
    case (op)
      OP_ADD:  return 3'b001;
      OP_SUB:  return 3'b010;
      OP_AND:  return 3'b011;
      OP_OR:   return 3'b100;
      OP_NOT:  return 3'b101;
      OP_SHR:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] cw_of(input state_t s, input logic [2:0] alu);
    case (s)
      S_F0:    return 16'h0002;
      S_F1:    return 16'h0020;
      S_F2:    return 16'h0005;
      S_JU:    return 16'h0100;
      S_E0:    return 16'h0008;
      S_ST1:   return 16'h0400;
      S_ST2:   return 16'h0800;
      S_RD:    return 16'h0020;
      S_BR:    return 16'h0010;
      S_EA:    return {1'b0, alu, 12'h040};
      S_HLT:   return 16'h8000;
      default: return 16'h0000;
    endcase
  endfunction

  assign wait_done = (wait_q == 4'(MEM_WAIT));

  // NOTE: every variable gets a default at the top so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (wait_done) state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        case (bus.ir_opcode)
          OP_HALT: begin
            state_d = S_HLT;
            retire  = 1'b1;
          end
          OP_JMP: state_d = S_JU;
          OP_JMPGEZ: begin
            if (!bus.acc_sign) begin
              state_d = S_JU;
            end else begin
              state_d = S_F0;
              retire  = 1'b1;
            end
          end
          OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_E0;
          OP_NOT, OP_SHR: state_d = S_EA;
          default: state_d = S_F0;
        endcase
      end
      S_JU: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_E0:   state_d = (bus.ir_opcode == OP_STORE) ? S_ST1 : S_RD;
      S_ST1:  state_d = S_ST2;
      S_ST2: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_RD:   if (wait_done) state_d = S_BR;
      S_BR:   state_d = S_EA;
      S_EA: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_HLT:  state_d = S_HLT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  // and clear on the same asynchronous reset edge as the state itself.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_q        <= 4'd0;
      instr_count_q <= 16'd0;
      cw_q          <= 16'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= ((state_q == S_F1 || state_q == S_RD) && !wait_done) ? wait_q + 4'd1 : 4'd0;
      cw_q     <= cw_of(state_d, alu_of(bus.ir_opcode));
      halted_q <= (state_d == S_HLT);
      if (retire) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  // The opcode is only valid from DEC onward, so the illegal flag is decoded live in DEC.
  assign bus.illegal_op = (state_q == S_DEC) &&
                          !(bus.ir_opcode inside {[OP_STORE:OP_SHR]});
  assign bus.control_signals = cw_q;
  assign bus.halted          = halted_q;
  assign bus.instr_count     = instr_count_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with MEM_WAIT=1: fetch sequence, each instruction class,
// illegal opcode, halt, asynchronous reset mid-read and instruction-counter wrap.
module tb_cpu_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu_ctrl_if bus ();

  cpu_ctrl_fsm #(.MEM_WAIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_cw(input string tag, input logic [15:0] exp);
    step();
    chk(tag, bus.control_signals, exp);
  endtask

  // From F0: F1 twice (MEM_WAIT=1), F2, then DEC
  task automatic fetch_from_f0();
    step_cw("f1a", 16'h0020);
    step_cw("f1b", 16'h0020);
    step_cw("f2", 16'h0005);
    step_cw("dec", 16'h0000);
  endtask

  task automatic start_cpu();
    bus.start = 1'b1;
    step_cw("f0_start", 16'h0002);
    bus.start = 1'b0;
  endtask

  // Read/write to memory must never overlap on the control word
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(bus.control_signals[5] && bus.control_signals[10]) &&
              !(bus.control_signals[5] && bus.control_signals[11])) else begin
        errors++;
        $error("FAIL cw_exclusive observed=%h expected=no_5_with_10_or_11", bus.control_signals);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.ir_opcode = 8'h03;
    bus.acc_sign  = 1'b0;
    #12;
    chk("rst_cw", bus.control_signals, 16'h0000);
    chk("rst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rst_illegal", {15'd0, bus.illegal_op}, 16'd0);
    chk("rst_count", bus.instr_count, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    step_cw("idle_hold", 16'h0000);

    // ADD: E0, RD x2, BR, EA with ALU op 001
    start_cpu();
    fetch_from_f0();
    chk("add_legal", {15'd0, bus.illegal_op}, 16'd0);
    step_cw("add_e0", 16'h0008);
    step_cw("add_rd1", 16'h0020);
    step_cw("add_rd2", 16'h0020);
    step_cw("add_br", 16'h0010);
    step_cw("add_ea", 16'h1040);
    step_cw("add_f0", 16'h0002);
    chk("add_count", bus.instr_count, 16'd1);

    // STORE: E0, ACC->MBR, MBR->MEM
    bus.ir_opcode = 8'h01;
    fetch_from_f0();
    step_cw("st_e0", 16'h0008);
    step_cw("st_st1", 16'h0400);
    step_cw("st_st2", 16'h0800);
    step_cw("st_f0", 16'h0002);
    chk("st_count", bus.instr_count, 16'd2);

    // JMPGEZ not taken retires straight from DEC
    bus.ir_opcode = 8'h05;
    bus.acc_sign  = 1'b1;
    fetch_from_f0();
    step_cw("jgez_nt_f0", 16'h0002);
    chk("jgez_nt_count", bus.instr_count, 16'd3);

    // JMPGEZ taken goes through JU
    bus.acc_sign = 1'b0;
    fetch_from_f0();
    step_cw("jgez_t_ju", 16'h0100);
    step_cw("jgez_t_f0", 16'h0002);
    chk("jgez_t_count", bus.instr_count, 16'd4);

    // NOT skips memory: DEC -> EA with ALU op 101
    bus.ir_opcode = 8'h0A;
    fetch_from_f0();
    step_cw("not_ea", 16'h5040);
    step_cw("not_f0", 16'h0002);
    chk("not_count", bus.instr_count, 16'd5);

    // Illegal opcode: one-cycle pulse in DEC, not retired
    bus.ir_opcode = 8'hFF;
    fetch_from_f0();
    chk("ill_pulse", {15'd0, bus.illegal_op}, 16'd1);
    step_cw("ill_f0", 16'h0002);
    chk("ill_pulse_end", {15'd0, bus.illegal_op}, 16'd0);
    chk("ill_count", bus.instr_count, 16'd5);

    // LOAD interrupted by reset during the memory read
    bus.ir_opcode = 8'h02;
    fetch_from_f0();
    step_cw("ld_e0", 16'h0008);
    step_cw("ld_rd1", 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    chk("rdrst_cw", bus.control_signals, 16'h0000);
    chk("rdrst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rdrst_count", bus.instr_count, 16'd0);
    @(negedge clk) rst_n = 1'b1;

    // HALT: retires, holds 8000 and halted, ignores start
    bus.ir_opcode = 8'h07;
    start_cpu();
    fetch_from_f0();
    step_cw("hlt_cw", 16'h8000);
    chk("hlt_halted", {15'd0, bus.halted}, 16'd1);
    chk("hlt_count", bus.instr_count, 16'd1);
    bus.start = 1'b1;
    step_cw("hlt_hold1", 16'h8000);
    step_cw("hlt_hold2", 16'h8000);
    chk("hlt_halted_hold", {15'd0, bus.halted}, 16'd1);
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("hltrst_cw", bus.control_signals, 16'h0000);
    chk("hltrst_halted", {15'd0, bus.halted}, 16'd0);
    @(negedge clk) rst_n = 1'b1;

    // Counter wrap: preload 0xFFFF in IDLE, then retire one JMP
    force dut.instr_count_q = 16'hFFFF;
    #1 release dut.instr_count_q;
    chk("wrap_pre", bus.instr_count, 16'hFFFF);
    bus.ir_opcode = 8'h06;
    start_cpu();
    fetch_from_f0();
    step_cw("jmp_ju", 16'h0100);
    step_cw("jmp_f0", 16'h0002);
    chk("wrap_post", bus.instr_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
